// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by the CPU's 9-bit {valid, byte} console port.
// A small FIFO absorbs bursts; bytes arriving while the FIFO is full are dropped and flagged.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_LOG2    = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [8:0]           uart_in,
    output logic                 tx,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   level,
    output logic                 overflow
);

    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int LVL_W  = FIFO_LOG2 + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                 state_q,    state_d;
    logic [FIFO_LOG2-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [FIFO_LOG2-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]       level_q,    level_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             shift_q,    shift_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [BAUD_W-1:0]      baud_q,     baud_d;
    logic                   tx_q,       tx_d;
    logic [7:0]             mem_q [DEPTH];

    logic push, pop, push_ok, baud_wrap;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        tx_d       = tx_q;

        push      = uart_in[8];
        pop       = (state_q == IDLE) && (level_q != '0);
        // A full FIFO still accepts a byte when the head leaves on the same edge.
        push_ok   = push && ((level_q != LVL_W'(DEPTH)) || pop);
        baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        if (push_ok)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !push_ok)
            overflow_d = 1'b1;

        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (state_q == IDLE)
            baud_d = '0;
        else
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d  = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            tx_q       <= tx_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= uart_in[7:0];
    end

    assign tx       = tx_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a serial
// monitor decodes frames off tx at bit centres and compares them in order.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int FL2 = 4;

    logic           clock;
    logic           reset_n;
    logic [8:0]     uart_in;
    logic           tx;
    logic           busy;
    logic [FL2:0]   level;
    logic           overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b1;
    logic [7:0] exp_q [$];
    logic [7:0] mon_b;
    logic [7:0] mon_exp;
    logic       mon_ok;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(FL2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .uart_in  (uart_in),
        .tx       (tx),
        .busy     (busy),
        .level    (level),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives one byte at the current negedge; the following posedge accepts it.
    task automatic push(input logic [7:0] b, input bit expect_out);
        uart_in = {1'b1, b};
        if (expect_out) exp_q.push_back(b);
        tick(1);
        uart_in = 9'h000;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int c = 0;
        while ((busy || exp_q.size() != 0) && c < max_cycles) begin
            tick(1);
            c++;
        end
        check(name, {31'd0, busy || exp_q.size() != 0}, 32'd0);
        tick(3);
    endtask

    // Serial monitor: first low sample marks edge s; centres at s+2, s+6+4i, s+38.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_on && reset_n && tx === 1'b0) begin
                tick(2);
                mon_ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    tick(4);
                    mon_b[i] = tx;
                end
                tick(4);
                mon_ok = mon_ok && (tx === 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {23'd0, mon_ok, mon_b}, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame", {23'd0, mon_ok, mon_b}, {23'd0, 1'b1, mon_exp});
                end
            end
        end
    end

    initial begin
        uart_in = 9'h000;
        reset_n = 1'b0;
        tick(3);
        check("rst_tx",       {31'd0, tx},       32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_level",    {27'd0, level},    32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single byte 0x41: edge 0 push, start at edge 1, stop ends at edge 40.
        push(8'h41, 1'b1);
        check("single_lvl_e0",  {27'd0, level}, 32'd1);
        check("single_tx_e0",   {31'd0, tx},    32'd1);
        check("single_busy_e0", {31'd0, busy},  32'd1);
        tick(1);
        check("single_tx_e1",   {31'd0, tx},    32'd0);
        check("single_lvl_e1",  {27'd0, level}, 32'd0);
        tick(3);
        check("single_tx_e4",   {31'd0, tx},    32'd0);
        tick(1);
        check("single_tx_e5",   {31'd0, tx},    32'd1);
        tick(35);
        check("single_busy_e40", {31'd0, busy}, 32'd1);
        check("single_tx_e40",   {31'd0, tx},   32'd1);
        tick(1);
        check("single_busy_e41", {31'd0, busy}, 32'd0);
        wait_drain(200, "single_drain");

        // Back-to-back "Hi": second start bit on edge 42.
        push(8'h48, 1'b1);
        push(8'h69, 1'b1);
        tick(40);
        check("b2b_tx_e41",   {31'd0, tx},   32'd1);
        check("b2b_busy_e41", {31'd0, busy}, 32'd1);
        tick(1);
        check("b2b_tx_e42",   {31'd0, tx},   32'd0);
        wait_drain(300, "b2b_drain");

        // Overflow: 18 back-to-back pushes, the last one is dropped.
        for (int i = 0; i < 17; i++) push(8'(i), 1'b1);
        check("ovf_lvl_e16", {27'd0, level},    32'd16);
        check("ovf_flag_e16", {31'd0, overflow}, 32'd0);
        push(8'h11, 1'b0);
        check("ovf_lvl_e17", {27'd0, level},    32'd16);
        check("ovf_flag_e17", {31'd0, overflow}, 32'd1);
        wait_drain(1500, "ovf_drain");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Wrap-around: three bursts of ten bytes.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 10; i++) push(8'(8'h80 + b * 16 + i), 1'b1);
            check("wrap_lvl", {27'd0, level}, 32'd9);
            wait_drain(1000, "wrap_drain");
        end

        // Reset during data bit 3 of the first frame (edges 17..20).
        mon_on = 1'b0;
        push(8'h55, 1'b0);
        push(8'hAA, 1'b0);
        tick(17);
        reset_n = 1'b0;
        #1;
        check("rstmid_tx",       {31'd0, tx},       32'd1);
        check("rstmid_level",    {27'd0, level},    32'd0);
        check("rstmid_busy",     {31'd0, busy},     32'd0);
        check("rstmid_overflow", {31'd0, overflow}, 32'd0);
        tick(3);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 60; i++) begin
                tick(1);
                if (tx !== 1'b1 || busy !== 1'b0) bad++;
            end
            check("rstmid_quiet", bad, 32'd0);
        end

        // Data bits with valid low are ignored.
        uart_in = 9'h0FF;
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                tick(1);
                if (level !== '0 || tx !== 1'b1 || busy !== 1'b0) bad++;
            end
            check("ignored_quiet", bad, 32'd0);
        end
        uart_in = 9'h000;
        tick(1);

        // Normal operation after reset.
        push(8'h3C, 1'b1);
        wait_drain(200, "post_rst_drain");
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
